// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm
// Credit controller for a vending machine. It counts coins in 5-cent units,
// decides when to vend, works out the change, and drives the 4-bit credit
// code shown on the display.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   nickel         coin level, 1 unit (high while the coin is sensed)
//   dime           coin level, 2 units
//   quarter        coin level, 5 units
//   cancel         refund request level
//   State[3:0]     displayed credit code, 0..PRICE_UNITS
//   dispense       one-cycle pulse: vend the product
//   change_valid   one-cycle pulse: change is valid
//   change[3:0]    units to return; only meaningful with change_valid
//   coin_rejected  one-cycle pulse: a coin edge was discarded
//
// All outputs are registered, so they follow the input edge by one cycle.
module vend_credit_fsm #(
  parameter int PRICE_UNITS   = 8,
  parameter int VEND_CYCLES   = 4,
  parameter int REFUND_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       cancel,
  output logic [3:0] State,
  output logic       dispense,
  output logic       change_valid,
  output logic [3:0] change,
  output logic       coin_rejected
);

  localparam int MAX_CYCLES = (VEND_CYCLES > REFUND_CYCLES) ? VEND_CYCLES : REFUND_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] VEND_LOAD   = CNT_W'(VEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFUND_LOAD = CNT_W'(REFUND_CYCLES - 1);
  localparam logic [3:0]       PRICE4      = 4'(PRICE_UNITS);
  localparam logic [4:0]       PRICE5      = 5'(PRICE_UNITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    REFUND = 2'd3
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [3:0]       credit_q, credit_d;
  logic [3:0]       code_q, code_d;
  logic             dispense_q, dispense_d;
  logic             change_valid_q, change_valid_d;
  logic [3:0]       change_q, change_d;
  logic             coin_rejected_q, coin_rejected_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  // History bit order: {cancel, quarter, dime, nickel}
  logic [3:0]       hist_q, hist_d;

  logic       ev_nickel, ev_dime, ev_quarter, ev_cancel;
  logic [1:0] coin_cnt;
  logic [4:0] coin_value;
  logic [4:0] sum;

  // Rising-edge events: the level is high now and was low last cycle.
  assign ev_nickel  = nickel  & ~hist_q[0];
  assign ev_dime    = dime    & ~hist_q[1];
  assign ev_quarter = quarter & ~hist_q[2];
  assign ev_cancel  = cancel  & ~hist_q[3];

  assign coin_cnt = {1'b0, ev_nickel} + {1'b0, ev_dime} + {1'b0, ev_quarter};

  // Only used when exactly one coin event is present.
  always_comb begin
    coin_value = 5'd0;
    if (ev_nickel)       coin_value = 5'd1;
    else if (ev_dime)    coin_value = 5'd2;
    else if (ev_quarter) coin_value = 5'd5;
  end

  // Five bits: worst case is (PRICE_UNITS-1) + 5 = 12.
  assign sum = {1'b0, credit_q} + coin_value;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q           <= IDLE;
      credit_q        <= 4'd0;
      code_q          <= 4'd0;
      dispense_q      <= 1'b0;
      change_valid_q  <= 1'b0;
      change_q        <= 4'd0;
      coin_rejected_q <= 1'b0;
      phase_q         <= '0;
      hist_q          <= 4'd0;
    end else begin
      fsm_q           <= fsm_d;
      credit_q        <= credit_d;
      code_q          <= code_d;
      dispense_q      <= dispense_d;
      change_valid_q  <= change_valid_d;
      change_q        <= change_d;
      coin_rejected_q <= coin_rejected_d;
      phase_q         <= phase_d;
      hist_q          <= hist_d;
    end
  end

  // Next-state and next-output computation
  always_comb begin
    fsm_d           = fsm_q;
    credit_d        = credit_q;
    code_d          = code_q;
    dispense_d      = 1'b0;
    change_valid_d  = 1'b0;
    change_d        = change_q;
    coin_rejected_d = 1'b0;
    phase_d         = phase_q;
    // History follows the inputs in every state so a held level never
    // produces a second event, even across VEND/REFUND.
    hist_d          = {cancel, quarter, dime, nickel};

    case (fsm_q)
      IDLE, CREDIT: begin
        if (ev_cancel && (fsm_q == CREDIT)) begin
          // Cancel beats any simultaneous coin; refund is the credit held
          // before this cycle.
          change_d        = credit_q;
          change_valid_d  = 1'b1;
          credit_d        = 4'd0;
          code_d          = 4'd0;
          fsm_d           = REFUND;
          phase_d         = REFUND_LOAD;
          coin_rejected_d = (coin_cnt != 2'd0);
        end else if (coin_cnt > 2'd1) begin
          coin_rejected_d = 1'b1;
        end else if (coin_cnt == 2'd1) begin
          if (sum < PRICE5) begin
            credit_d = sum[3:0];
            code_d   = sum[3:0];
            fsm_d    = CREDIT;
          end else begin
            dispense_d     = 1'b1;
            change_valid_d = 1'b1;
            // Result is at most 4, so the low four bits are exact.
            change_d       = sum[3:0] - PRICE4;
            code_d         = PRICE4;
            credit_d       = 4'd0;
            fsm_d          = VEND;
            phase_d        = VEND_LOAD;
          end
        end
      end

      VEND, REFUND: begin
        coin_rejected_d = (coin_cnt != 2'd0);
        if (phase_q == '0) begin
          fsm_d  = IDLE;
          code_d = 4'd0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // Output drive
  always_comb begin
    State         = code_q;
    dispense      = dispense_q;
    change_valid  = change_valid_q;
    change        = change_q;
    coin_rejected = coin_rejected_q;
  end

endmodule

// File: tb/tb_vend_credit_fsm.sv
module tb_vend_credit_fsm;

  logic       clk;
  logic       reset;
  logic       nickel, dime, quarter, cancel;
  logic [3:0] State;
  logic       dispense;
  logic       change_valid;
  logic [3:0] change;
  logic       coin_rejected;

  int total;
  int bad;

  vend_credit_fsm #(
    .PRICE_UNITS  (8),
    .VEND_CYCLES  (4),
    .REFUND_CYCLES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .nickel       (nickel),
    .dime         (dime),
    .quarter      (quarter),
    .cancel       (cancel),
    .State        (State),
    .dispense     (dispense),
    .change_valid (change_valid),
    .change       (change),
    .coin_rejected(coin_rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs are applied between edges; outputs are sampled 1 time unit after
  // the edge that captured them.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int disp,
                         input int cv, input int rej);
    chk({tag, ".State"}, int'(State), st);
    chk({tag, ".dispense"}, int'(dispense), disp);
    chk({tag, ".change_valid"}, int'(change_valid), cv);
    chk({tag, ".coin_rejected"}, int'(coin_rejected), rej);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    nickel  = 1'b0;
    dime    = 1'b0;
    quarter = 1'b0;
    cancel  = 1'b0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    chk("reset.change", int'(change), 0);
    reset = 1'b0;
    step();

    // Nickel, dime, dime -> 1, 3, 5
    nickel = 1'b1; step(); chk_all("nickel1", 1, 0, 0, 0);
    nickel = 1'b0; step(); chk("hold1", int'(State), 1);
    dime = 1'b1;   step(); chk_all("dime3", 3, 0, 0, 0);
    dime = 1'b0;   step();
    dime = 1'b1;   step(); chk_all("dime5", 5, 0, 0, 0);
    dime = 1'b0;   step();

    // Quarter from 5 -> vend with change 2, four cycles at 8
    quarter = 1'b1; step();
    chk_all("q_vend", 8, 1, 1, 0);
    chk("q_vend.change", int'(change), 2);
    quarter = 1'b0; step(); chk_all("vend2", 8, 0, 0, 0);
    dime = 1'b1;    step(); chk_all("vend3_dime", 8, 0, 0, 1);
    dime = 1'b0;    step(); chk_all("vend4", 8, 0, 0, 0);
    step();         chk_all("vend_done", 0, 0, 0, 0);
    chk("change_hold", int'(change), 2);

    // Credit 6, then dime -> exact price, change 0
    nickel = 1'b1;  step(); chk("c6_n", int'(State), 1);
    nickel = 1'b0;  step();
    quarter = 1'b1; step(); chk("c6_q", int'(State), 6);
    quarter = 1'b0; step();
    dime = 1'b1;    step();
    chk_all("exact_vend", 8, 1, 1, 0);
    chk("exact_vend.change", int'(change), 0);
    dime = 1'b0;
    step(); step(); step();
    chk("exact_last8", int'(State), 8);
    step();
    chk("exact_idle", int'(State), 0);

    // Credit 3, cancel together with nickel
    nickel = 1'b1; step();
    nickel = 1'b0; step();
    dime = 1'b1;   step(); chk("c3", int'(State), 3);
    dime = 1'b0;   step();
    cancel = 1'b1; nickel = 1'b1; step();
    chk_all("cancel3", 0, 0, 1, 1);
    chk("cancel3.change", int'(change), 3);
    cancel = 1'b0; nickel = 1'b0; step();
    chk_all("refund2", 0, 0, 0, 0);
    chk("refund2.change", int'(change), 3);
    step();
    // Back in IDLE: a nickel counts again
    nickel = 1'b1; step(); chk("after_refund", int'(State), 1);
    nickel = 1'b0; step();
    cancel = 1'b1; step();
    chk_all("cancel1", 0, 0, 1, 0);
    chk("cancel1.change", int'(change), 1);
    cancel = 1'b0; step(); step(); step();

    // Cancel in IDLE does nothing
    cancel = 1'b1; step(); chk_all("cancel_idle", 0, 0, 0, 0);
    cancel = 1'b0; step();

    // Two coins at once in IDLE
    nickel = 1'b1; dime = 1'b1; step();
    chk_all("two_coins", 0, 0, 0, 1);
    nickel = 1'b0; dime = 1'b0; step();
    chk_all("two_coins_after", 0, 0, 0, 0);

    // Nickel held ten cycles -> one increment
    nickel = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk_all("nickel_held", 1, 0, 0, 0);
    nickel = 1'b0; step();

    // Reach VEND from 1: quarter -> 6, dime -> 8
    quarter = 1'b1; step(); chk("pre_rst6", int'(State), 6);
    quarter = 1'b0; step();
    dime = 1'b1;    step(); chk_all("pre_rst_vend", 8, 1, 1, 0);
    dime = 1'b0;
    // Reset during second VEND cycle with quarter held
    reset = 1'b1; quarter = 1'b1; step();
    chk_all("mid_vend_rst", 0, 0, 0, 0);
    chk("mid_vend_rst.change", int'(change), 0);
    reset = 1'b0; step();
    chk_all("q_after_rst", 5, 0, 0, 0);
    step();
    chk_all("q_held", 5, 0, 0, 0);
    quarter = 1'b0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

endmodule
